// File: rtl/core_bus_pkg.sv
// rtl/core_bus_pkg.sv - shared master IDs and byte-enable constants for the core bus arbiter
package core_bus_pkg;

    typedef logic bus_master_id_t;

    localparam bus_master_id_t MID_IF  = 1'b0;
    localparam bus_master_id_t MID_LSU = 1'b1;

    localparam logic [3:0] BYTE_EN_ALL = 4'hf;

endpackage

// File: rtl/core_bus_arb_rsp_tracker.sv
// rtl/core_bus_arb_rsp_tracker.sv - in-order FIFO of master IDs owning outstanding reads
module core_bus_arb_rsp_tracker
    import core_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rest,
    input  logic           push_i,
    input  bus_master_id_t push_id_i,
    input  logic           pop_i,
    output bus_master_id_t head_id_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    bus_master_id_t mem_q [DEPTH];
    logic [AW-1:0]  wr_q, wr_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [CW-1:0]  count_q, count_d;
    logic           push_eff;
    logic           pop_eff;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign head_id_o = mem_q[rd_q];

    // A pop frees the slot in the same cycle, so push at full is honoured alongside it.
    assign pop_eff  = pop_i & ~empty_o;
    assign push_eff = push_i & (~full_o | pop_eff);

    always_comb begin
        wr_d    = wr_q + AW'(push_eff);
        rd_d    = rd_q + AW'(pop_eff);
        count_d = count_q + CW'(push_eff) - CW'(pop_eff);
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_q[wr_q] <= push_id_i;
        end
    end

endmodule

// File: rtl/core_bus_arb.sv
// rtl/core_bus_arb.sv - fetch/LSU to memory bus arbiter; CORE_BUS_ARB_LSU_PRIO_EN selects fixed LSU priority
module core_bus_arb
    import core_bus_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              m0_read,
    input  logic [ADDR_W-1:0] m0_address,
    output logic              m0_request_ready,
    output logic [DATA_W-1:0] m0_read_data,
    output logic              m0_read_data_valid,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_write_data,
    input  logic [3:0]        m1_byte_en,
    output logic              m1_request_ready,
    output logic [DATA_W-1:0] m1_read_data,
    output logic              m1_read_data_valid,
    output logic              s_read,
    output logic              s_write,
    output logic [ADDR_W-1:0] s_address,
    output logic [DATA_W-1:0] s_write_data,
    output logic [3:0]        s_byte_en,
    input  logic              s_request_ready,
    input  logic [DATA_W-1:0] s_read_data,
    input  logic              s_read_data_valid,
    output logic              err_unexpected
);

    bus_master_id_t trk_head;
    logic           trk_full;
    logic           trk_empty;
    logic           rsp_pop;
    logic           read_room;
    logic           elig0, elig1;
    logic           pick_lsu;
    logic           gnt0, gnt1;
    logic           accept;
    logic           push;
    logic           err_q, err_d;

    // Full implies non-empty, so any response in the cycle frees a slot for a new read.
    assign rsp_pop   = s_read_data_valid & ~trk_empty;
    assign read_room = ~trk_full | s_read_data_valid;

    assign elig0 = m0_read & read_room;
    assign elig1 = m1_write | (m1_read & read_room);

`ifdef CORE_BUS_ARB_LSU_PRIO_EN
    assign pick_lsu = 1'b1;
`else
    bus_master_id_t rr_last_q, rr_last_d;

    assign pick_lsu = (rr_last_q == MID_IF);

    always_comb begin
        rr_last_d = rr_last_q;
        if (accept) begin
            rr_last_d = gnt1 ? MID_LSU : MID_IF;
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            rr_last_q <= MID_LSU;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    assign gnt1 = elig1 & (~elig0 | pick_lsu);
    assign gnt0 = elig0 & ~gnt1;

    always_comb begin
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_address    = '0;
        s_write_data = '0;
        s_byte_en    = '0;
        if (gnt0) begin
            s_read    = 1'b1;
            s_address = m0_address;
            s_byte_en = BYTE_EN_ALL;
        end else if (gnt1) begin
            s_read       = m1_read;
            s_write      = m1_write;
            s_address    = m1_address;
            s_write_data = m1_write_data;
            s_byte_en    = m1_byte_en;
        end
    end

    assign m0_request_ready = gnt0 & s_request_ready;
    assign m1_request_ready = gnt1 & s_request_ready;
    assign accept           = (gnt0 | gnt1) & s_request_ready;
    assign push             = accept & s_read;

    assign m0_read_data       = s_read_data;
    assign m1_read_data       = s_read_data;
    assign m0_read_data_valid = rsp_pop & (trk_head == MID_IF);
    assign m1_read_data_valid = rsp_pop & (trk_head == MID_LSU);

    assign err_d          = err_q | (s_read_data_valid & trk_empty);
    assign err_unexpected = err_q;

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    core_bus_arb_rsp_tracker #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_tracker (
        .clk       (clk),
        .rest      (rest),
        .push_i    (push),
        .push_id_i (gnt1 ? MID_LSU : MID_IF),
        .pop_i     (rsp_pop),
        .head_id_o (trk_head),
        .full_o    (trk_full),
        .empty_o   (trk_empty)
    );

endmodule

// File: tb/tb_core_bus_arb.sv
// tb/tb_core_bus_arb.sv - self-checking bench for core_bus_arb with a queue-based reference model
module tb_core_bus_arb;

    localparam int MAXO = 4;
`ifdef CORE_BUS_ARB_LSU_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rest;
    logic        m0_read;
    logic [31:0] m0_address;
    logic        m0_request_ready;
    logic [31:0] m0_read_data;
    logic        m0_read_data_valid;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_address;
    logic [31:0] m1_write_data;
    logic [3:0]  m1_byte_en;
    logic        m1_request_ready;
    logic [31:0] m1_read_data;
    logic        m1_read_data_valid;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_address;
    logic [31:0] s_write_data;
    logic [3:0]  s_byte_en;
    logic        s_request_ready;
    logic [31:0] s_read_data;
    logic        s_read_data_valid;
    logic        err_unexpected;

    int total = 0;
    int bad   = 0;
    int q[$];
    int rr_last;
    bit err_m;
    int last_w;
    bit last_acc;

    always #5 clk = ~clk;

    core_bus_arb dut (
        .clk                (clk),
        .rest               (rest),
        .m0_read            (m0_read),
        .m0_address         (m0_address),
        .m0_request_ready   (m0_request_ready),
        .m0_read_data       (m0_read_data),
        .m0_read_data_valid (m0_read_data_valid),
        .m1_read            (m1_read),
        .m1_write           (m1_write),
        .m1_address         (m1_address),
        .m1_write_data      (m1_write_data),
        .m1_byte_en         (m1_byte_en),
        .m1_request_ready   (m1_request_ready),
        .m1_read_data       (m1_read_data),
        .m1_read_data_valid (m1_read_data_valid),
        .s_read             (s_read),
        .s_write            (s_write),
        .s_address          (s_address),
        .s_write_data       (s_write_data),
        .s_byte_en          (s_byte_en),
        .s_request_ready    (s_request_ready),
        .s_read_data        (s_read_data),
        .s_read_data_valid  (s_read_data_valid),
        .err_unexpected     (err_unexpected)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_read = 0; m0_address = 0;
        m1_read = 0; m1_write = 0; m1_address = 0; m1_write_data = 0; m1_byte_en = 0;
        s_request_ready = 0; s_read_data = 0; s_read_data_valid = 0;
    endtask

    task automatic model_reset();
        q.delete();
        rr_last  = 1;
        err_m    = 0;
        last_w   = -1;
        last_acc = 0;
    endtask

    task automatic do_reset();
        rest = 0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rest = 1;
    endtask

    // Checks every output against the model for the current inputs, then advances one clock.
    task automatic step(input string tag);
        int  n, w;
        bit  pop, room, c0, c1, acc;
        #1;
        n    = q.size();
        pop  = s_read_data_valid && (n > 0);
        room = (n < MAXO) || pop;
        c0   = m0_read && room;
        c1   = m1_write || (m1_read && room);
        w    = -1;
        if (c0 && c1)  w = PRIO ? 1 : (rr_last == 0 ? 1 : 0);
        else if (c0)   w = 0;
        else if (c1)   w = 1;
        acc = (w >= 0) && s_request_ready;

        chk({tag, " s_read"},  s_read,  (w == 0) || (w == 1 && m1_read));
        chk({tag, " s_write"}, s_write, (w == 1) && m1_write);
        chk({tag, " m0_rdy"},  m0_request_ready, (w == 0) && s_request_ready);
        chk({tag, " m1_rdy"},  m1_request_ready, (w == 1) && s_request_ready);
        if (w == 0) begin
            chk({tag, " s_addr"}, s_address, m0_address);
            chk({tag, " s_be"},   s_byte_en, 4'hf);
        end else if (w == 1) begin
            chk({tag, " s_addr"}, s_address, m1_address);
            chk({tag, " s_be"},   s_byte_en, m1_byte_en);
            if (m1_write) chk({tag, " s_wdata"}, s_write_data, m1_write_data);
        end
        chk({tag, " m0_vld"}, m0_read_data_valid, pop && q[0] == 0);
        chk({tag, " m1_vld"}, m1_read_data_valid, pop && q[0] == 1);
        if (pop) begin
            chk({tag, " m0_rdata"}, m0_read_data, s_read_data);
            chk({tag, " m1_rdata"}, m1_read_data, s_read_data);
        end
        chk({tag, " err"}, err_unexpected, err_m);

        if (pop) void'(q.pop_front());
        if (acc && (w == 0 || m1_read)) q.push_back(w);
        if (acc) rr_last = w;
        if (s_read_data_valid && n == 0) err_m = 1;
        last_w   = w;
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        m0_read = 0; m1_read = 0; m1_write = 0;
        for (int i = 0; i < MAXO + 2 && q.size() > 0; i++) begin
            s_read_data_valid = 1;
            s_read_data = $urandom;
            step(tag);
        end
        s_read_data_valid = 0;
    endtask

    initial begin
        idle_inputs();
        do_reset();

        // reset state
        #1;
        chk("rst err", err_unexpected, 0);
        chk("rst s_read", s_read, 0);
        chk("rst m0_vld", m0_read_data_valid, 0);
        step("rst");

        // both masters read continuously, responses three cycles after acceptance
        m0_read = 1; m1_read = 1; s_request_ready = 1;
        for (int i = 0; i < 8; i++) begin
            m0_address = 32'h1000 + 32'(i * 4);
            m1_address = 32'h8000 + 32'(i * 4);
            s_read_data_valid = (i >= 3);
            s_read_data = $urandom;
            #1;
            chk("alt m0_rdy", m0_request_ready, PRIO ? 0 : (i % 2 == 0));
            chk("alt m1_rdy", m1_request_ready, PRIO ? 1 : (i % 2 == 1));
            if (i >= 3) chk("alt route m0", m0_read_data_valid, PRIO ? 0 : ((i - 3) % 2 == 0));
            step("alt");
        end
        drain("alt drain");

        // fill the tracker with fetch reads, then the bypass on a same-cycle response
        s_request_ready = 1; m0_read = 1; m0_address = 32'h100;
        for (int i = 0; i < 4; i++) begin
            #1; chk("fill rdy", m0_request_ready, 1);
            step("fill");
            m0_address += 4;
        end
        for (int i = 0; i < 2; i++) begin
            #1; chk("full held", m0_request_ready, 0);
            step("full");
        end
        s_read_data_valid = 1; s_read_data = 32'hCAFE0100;
        #1;
        chk("bypass rdy", m0_request_ready, 1);
        chk("bypass vld", m0_read_data_valid, 1);
        step("bypass");
        s_read_data_valid = 0; m0_address += 4;
        #1; chk("still full", m0_request_ready, 0);
        step("still full");
        drain("full drain");

        // LSU write interleaved between fetch reads
        m0_read = 1; m0_address = 32'h300;
        step("iw r0");
        m0_read = 0;
        m1_write = 1; m1_address = 32'h2000; m1_write_data = 32'hDEADBEEF; m1_byte_en = 4'h3;
        #1;
        chk("iw s_write", s_write, 1);
        chk("iw wdata", s_write_data, 32'hDEADBEEF);
        chk("iw be", s_byte_en, 4'h3);
        step("iw w");
        m1_write = 0; m0_read = 1; m0_address = 32'h304;
        step("iw r1");
        m0_read = 0;
        for (int i = 0; i < 2; i++) begin
            s_read_data_valid = 1; s_read_data = 32'h5000 + 32'(i);
            #1; chk("iw route", m0_read_data_valid, 1);
            step("iw rsp");
        end
        s_read_data_valid = 0;
        #1; chk("iw no extra", m0_read_data_valid | m1_read_data_valid, 0);
        step("iw idle");

        // unexpected response after reset
        do_reset();
        s_read_data_valid = 1; s_read_data = 32'h1234;
        #1;
        chk("unexp m0_vld", m0_read_data_valid, 0);
        chk("unexp m1_vld", m1_read_data_valid, 0);
        step("unexp");
        s_read_data_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1; chk("unexp sticky", err_unexpected, 1);
            step("sticky");
        end
        do_reset();
        #1; chk("unexp cleared", err_unexpected, 0);

        // reset while reads are outstanding
        s_request_ready = 1; m0_read = 1; m0_address = 32'h400;
        step("rst out r0");
        m0_address = 32'h404;
        step("rst out r1");
        idle_inputs();
        rest = 0;
        model_reset();
        s_read_data_valid = 1;
        #1;
        chk("async m0_vld", m0_read_data_valid, 0);
        chk("async m1_vld", m1_read_data_valid, 0);
        chk("async s_read", s_read, 0);
        chk("async err", err_unexpected, 0);
        @(posedge clk);
        #1;
        rest = 1;
        step("post rst rsp");
        s_read_data_valid = 0;
        #1; chk("post rst err", err_unexpected, 1);
        step("post rst");

        // randomized traffic with request holding
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!(m0_read && !(last_acc && last_w == 0))) begin
                m0_read    = ($urandom_range(0, 1) == 1);
                m0_address = $urandom & 32'hFFFF_FFFC;
            end
            if (!((m1_read || m1_write) && !(last_acc && last_w == 1))) begin
                case ($urandom_range(0, 3))
                    0:       begin m1_read = 0; m1_write = 0; end
                    2:       begin m1_read = 0; m1_write = 1; end
                    default: begin m1_read = 1; m1_write = 0; end
                endcase
                m1_address    = $urandom & 32'hFFFF_FFFC;
                m1_write_data = $urandom;
                m1_byte_en    = 4'($urandom_range(1, 15));
            end
            s_request_ready   = ($urandom_range(0, 3) != 0);
            s_read_data_valid = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            s_read_data       = $urandom;
            step("rand");
        end
        drain("rand drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
